// File: rtl/_regfile.sv
// rtl/_regfile.sv - n x w register file, two bypassed read ports, busy scoreboard
// Read ports select through _mux; a same-cycle writeback bypasses both data and busy.

module _mux #(
  parameter int n = 8,
  parameter int w = 16
) (
  input  logic [$clog2(n)-1:0] sel_i,
  input  logic [n-1:0][w-1:0]  data_i,
  output logic [w-1:0]         data_o
);
  assign data_o = data_i[sel_i];
endmodule

module _regfile #(
  parameter int n = 8,
  parameter int w = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(n)-1:0] raddr_a,
  input  logic [$clog2(n)-1:0] raddr_b,
  output logic [w-1:0]         rdata_a,
  output logic [w-1:0]         rdata_b,
  output logic                 busy_a,
  output logic                 busy_b,
  input  logic                 we,
  input  logic [$clog2(n)-1:0] waddr,
  input  logic [w-1:0]         wdata,
  input  logic                 issue_en,
  input  logic [$clog2(n)-1:0] issue_dst,
  output logic                 issue_stall
);
  localparam int s = $clog2(n);

  logic [n-1:0][w-1:0] regs_q, regs_d;
  logic [n-1:0]        busy_q, busy_d;
  logic [w-1:0]        base_a, base_b;
  logic                hit_a, hit_b, hit_dst;

  _mux #(.n(n), .w(w)) u_mux_a (.sel_i(raddr_a), .data_i(regs_q), .data_o(base_a));
  _mux #(.n(n), .w(w)) u_mux_b (.sel_i(raddr_b), .data_i(regs_q), .data_o(base_b));

  assign hit_a   = we && (waddr == raddr_a);
  assign hit_b   = we && (waddr == raddr_b);
  assign hit_dst = we && (waddr == issue_dst);

  assign rdata_a     = hit_a ? wdata : base_a;
  assign rdata_b     = hit_b ? wdata : base_b;
  assign busy_a      = busy_q[raddr_a] & ~hit_a;
  assign busy_b      = busy_q[raddr_b] & ~hit_b;
  assign issue_stall = issue_en & busy_q[issue_dst] & ~hit_dst;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    // Set is applied after clear so a new producer on the written register keeps it busy.
    if (issue_en && !issue_stall) begin
      busy_d[issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  logic [s-1:0] unused_s;
  assign unused_s = '0;
endmodule

// File: tb/tb__regfile.sv
// tb/tb__regfile.sv - scoreboard bench for _regfile (n=8, w=16)
// Driver pushes hand-computed expectations; a negedge monitor pops and compares.

module tb__regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  raddr_a, raddr_b, waddr, issue_dst;
  logic [15:0] rdata_a, rdata_b, wdata;
  logic        busy_a, busy_b, we, issue_en, issue_stall;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        ba;
    logic        bb;
    logic        st;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  _regfile #(.n(8), .w(16)) dut (
    .clk(clk), .rst(rst),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_dst(issue_dst),
    .issue_stall(issue_stall)
  );

  task automatic chk(input string name, input string fld, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got %h expected %h", name, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "rdata_a", rdata_a, e.ra);
      chk(e.name, "rdata_b", rdata_b, e.rb);
      chk(e.name, "busy_a", {15'd0, busy_a}, {15'd0, e.ba});
      chk(e.name, "busy_b", {15'd0, busy_b}, {15'd0, e.bb});
      chk(e.name, "issue_stall", {15'd0, issue_stall}, {15'd0, e.st});
    end
  end

  task automatic expect_out(input string name, input logic [15:0] ra, input logic [15:0] rb,
                            input logic ba, input logic bb, input logic st);
    exp_t e;
    e.name = name; e.ra = ra; e.rb = rb; e.ba = ba; e.bb = bb; e.st = st;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic w_en,
                       input logic [2:0] wa, input logic [15:0] wd,
                       input logic i_en, input logic [2:0] dst);
    raddr_a = a; raddr_b = b; we = w_en; waddr = wa; wdata = wd;
    issue_en = i_en; issue_dst = dst;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 16'h0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(i[2:0], 3'(7 - i), 0, 0, 16'h0, 0, i[2:0]);
      expect_out("reset_read", 16'h0, 16'h0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 16'h0, 1, 3);
    expect_out("reset_issue_nostall", 16'h0, 16'h0, 0, 0, 0);
    tick();
    drive(3, 0, 1, 3, 16'hDEAD, 0, 0);
    expect_out("reset_issue_set", 16'hDEAD, 16'h0, 0, 0, 0);
    tick();
    drive(3, 0, 0, 0, 16'h0, 0, 0);
    expect_out("reset_issue_cleared", 16'hDEAD, 16'h0, 0, 0, 0);
    tick();

    drive(3, 0, 1, 3, 16'hBEEF, 0, 0);
    expect_out("write3_bypass", 16'hBEEF, 16'h0, 0, 0, 0);
    tick();
    drive(3, 3, 0, 0, 16'h0, 0, 0);
    expect_out("write3_read", 16'hBEEF, 16'hBEEF, 0, 0, 0);
    tick();
    drive(2, 4, 0, 0, 16'h0, 0, 0);
    expect_out("write3_others", 16'h0, 16'h0, 0, 0, 0);
    tick();

    drive(5, 3, 1, 5, 16'h1234, 0, 0);
    expect_out("bypass5", 16'h1234, 16'hBEEF, 0, 0, 0);
    tick();
    drive(5, 3, 0, 0, 16'h0, 0, 0);
    expect_out("bypass5_after", 16'h1234, 16'hBEEF, 0, 0, 0);
    tick();

    drive(5, 2, 0, 0, 16'h0, 1, 2);
    expect_out("issue2", 16'h1234, 16'h0, 0, 0, 0);
    tick();
    drive(5, 2, 0, 0, 16'h0, 0, 0);
    expect_out("issue2_busy", 16'h1234, 16'h0, 0, 1, 0);
    tick();
    drive(5, 2, 0, 0, 16'h0, 1, 2);
    expect_out("issue2_stall", 16'h1234, 16'h0, 0, 1, 1);
    tick();
    drive(5, 2, 0, 0, 16'h0, 0, 0);
    expect_out("issue2_still_busy", 16'h1234, 16'h0, 0, 1, 0);
    tick();
    drive(5, 2, 1, 2, 16'h00AA, 0, 0);
    expect_out("wb2_bypass", 16'h1234, 16'h00AA, 0, 0, 0);
    tick();
    drive(5, 2, 0, 0, 16'h0, 0, 0);
    expect_out("wb2_after", 16'h1234, 16'h00AA, 0, 0, 0);
    tick();

    drive(4, 2, 0, 0, 16'h0, 1, 4);
    expect_out("issue4", 16'h0, 16'h00AA, 0, 0, 0);
    tick();
    drive(4, 2, 0, 0, 16'h0, 0, 0);
    expect_out("issue4_busy", 16'h0, 16'h00AA, 1, 0, 0);
    tick();
    drive(4, 2, 1, 4, 16'h0C0D, 1, 4);
    expect_out("simul4", 16'h0C0D, 16'h00AA, 0, 0, 0);
    tick();
    drive(4, 2, 0, 0, 16'h0, 1, 4);
    expect_out("simul4_set_wins", 16'h0C0D, 16'h00AA, 1, 0, 1);
    tick();

    drive(4, 1, 1, 4, 16'h0C0D, 1, 1);
    expect_out("diff_set_clear", 16'h0C0D, 16'h0, 0, 0, 0);
    tick();
    drive(4, 1, 1, 6, 16'hFFFF, 1, 6);
    expect_out("diff_after", 16'h0C0D, 16'h0, 0, 1, 0);
    tick();
    drive(6, 1, 0, 0, 16'h0, 0, 0);
    expect_out("pre_reset", 16'hFFFF, 16'h0, 1, 1, 0);
    tick();

    rst = 1'b1;
    drive(0, 6, 1, 0, 16'h5555, 0, 0);
    expect_out("reset_cycle", 16'h5555, 16'hFFFF, 0, 1, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(i[2:0], 3'(i + 1), 0, 0, 16'h0, 0, 0);
      expect_out("post_reset", 16'h0, 16'h0, 0, 0, 0);
      tick();
    end

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
